xadc_sensor_poller: RTL and testbench



---
 rtl/xadc_sensor_poller_pkg.sv | 49 ++++
 rtl/xadc_sensor_poller_if.sv | 20 ++
 rtl/xadc_code_convert.sv | 65 ++++++
 rtl/xadc_sensor_poller.sv | 164 ++++++++++++++++
 tb/tb_xadc_sensor_poller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xadc_sensor_poller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xadc_sensor_poller_pkg                                          |
// | Purpose  : Shared types and constants for the XADC sensor poller: sequencer |
// |            state encoding, channel index type, DRP addresses of the on-die |
// |            sensors and the temperature conversion offset.                   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package xadc_sensor_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_NEXT    = 3'd4,
    ST_COMMIT  = 3'd5
  } state_t;

  // Channel index in sweep order.
  typedef logic [2:0] chan_t;

  localparam chan_t c_ch_temp    = 3'd0;
  localparam chan_t c_ch_vccint  = 3'd1;
  localparam chan_t c_ch_vccaux  = 3'd2;
  localparam chan_t c_ch_vccbram = 3'd3;
  localparam chan_t c_ch_psu     = 3'd4;

  localparam logic [6:0] c_addr_temp    = 7'h00;
  localparam logic [6:0] c_addr_vccint  = 7'h01;
  localparam logic [6:0] c_addr_vccaux  = 7'h02;
  localparam logic [6:0] c_addr_vccbram = 7'h06;

  // ((code * 63) >> 1) - offset yields degC in 8.8.
  localparam logic [17:0] c_temp_offset = 18'd69926;

  // DRP address for a channel; the aux channel address is a top-level parameter.
  function automatic logic [6:0] chan_addr(input chan_t ch, input logic [6:0] psu_addr);
    case (ch)
      c_ch_temp:    chan_addr = c_addr_temp;
      c_ch_vccint:  chan_addr = c_addr_vccint;
      c_ch_vccaux:  chan_addr = c_addr_vccaux;
      c_ch_vccbram: chan_addr = c_addr_vccbram;
      default:      chan_addr = psu_addr;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_sensor_poller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xadc_sensor_poller_if                                           |
// | Purpose  : DRP read-only bundle between the poller and the XADC primitive.  |
// |   drp_en   : one-cycle read strobe          (master -> slave)              |
// |   drp_addr : 7-bit register address         (master -> slave)              |
// |   drp_rdy  : read-complete strobe           (slave -> master)              |
// |   drp_do   : 16-bit read data, code [15:4]  (slave -> master)              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface xadc_sensor_poller_if;
  logic        drp_en;
  logic [6:0]  drp_addr;
  logic        drp_rdy;
  logic [15:0] drp_do;

  modport master (output drp_en, output drp_addr, input drp_rdy, input drp_do);
  modport slave  (input drp_en, input drp_addr, output drp_rdy, output drp_do);
endinterface
`default_nettype wire

// File: rtl/xadc_code_convert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xadc_code_convert                                               |
// | Purpose  : Converts a 12-bit XADC code to the reported 8.8 format for the   |
// |            given channel; result is registered one cycle after load.       |
// |   clk, rst     : clock, asynchronous active-high reset                     |
// |   load         : capture a conversion this cycle                           |
// |   chan, code12 : channel index and raw 12-bit code                         |
// |   result       : converted 16-bit value                                    |
// |   result_valid : high the cycle after load                                 |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module xadc_code_convert
  import xadc_sensor_poller_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  load,
  input  chan_t      chan,
  input  wire logic [11:0] code12,
  output logic [15:0] result,
  output logic        result_valid
);

  logic [13:0]        w_volt_prod;
  logic [15:0]        w_volt;
  logic [17:0]        w_temp_prod;
  logic [17:0]        w_temp_half;
  logic signed [17:0] w_temp_diff;
  logic [15:0]        w_temp;
  logic               w_unused_diff_bit;

  always_comb begin
    // Voltage: code * 3 / 16, max 12285 fits 14 bits.
    w_volt_prod = {2'b00, code12} * 14'd3;
    w_volt      = {2'b00, w_volt_prod} >> 4;
    // Temperature: the halved product never sets bit 17, so it is a valid
    // non-negative signed operand.
    w_temp_prod = {6'd0, code12} * 18'd63;
    w_temp_half = w_temp_prod >> 1;
    w_temp_diff = $signed(w_temp_half) - $signed(c_temp_offset);
    w_temp      = w_temp_diff[17] ? 16'h0000 : w_temp_diff[15:0];
  end

  // Bit 16 of the difference is always zero for a non-negative result.
  assign w_unused_diff_bit = w_temp_diff[16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= 16'h0000;
      result_valid <= 1'b0;
    end else begin
      result_valid <= load;
      if (load) begin
        case (chan)
          c_ch_temp: result <= w_temp;
          c_ch_psu:  result <= {4'h0, code12};
          default:   result <= w_volt;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xadc_sensor_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xadc_sensor_poller                                              |
// | Purpose  : Sweeps XADC channels (temp, VCCINT, VCCAUX, VCCBRAM, aux PSU)    |
// |            over DRP, converts codes, and publishes all readings together.  |
// |   clk, rst      : clock, asynchronous active-high reset                    |
// |   drp           : DRP master port (strobe, address, ready, data)           |
// |   die_temp      : degC 8.8, floored at 0                                   |
// |   volt_core/ram/aux : VCCINT / VCCBRAM / VCCAUX, volts 8.8                 |
// |   psu_temp      : raw aux code                                             |
// |   sample_valid  : one-cycle pulse when a new set is published              |
// |   timeout_count : saturating count of abandoned reads                      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module xadc_sensor_poller
  import xadc_sensor_poller_pkg::*;
#(
  parameter logic [31:0] POLL_INTERVAL = 32'd1000000,
  parameter logic [15:0] DRP_TIMEOUT   = 16'd255,
  parameter logic [6:0]  PSU_TEMP_ADDR = 7'h10
) (
  input  wire logic            clk,
  input  wire logic            rst,
  xadc_sensor_poller_if.master drp,
  output logic [15:0]          die_temp,
  output logic [15:0]          volt_core,
  output logic [15:0]          volt_ram,
  output logic [15:0]          volt_aux,
  output logic [11:0]          psu_temp,
  output logic                 sample_valid,
  output logic [7:0]           timeout_count
);

  state_t      r_state;
  chan_t       r_channel;
  logic [31:0] r_interval;
  logic [15:0] r_wait_cnt;
  logic [11:0] r_code12;

  // Shadow set, published atomically at commit.
  logic [15:0] r_sh_temp;
  logic [15:0] r_sh_core;
  logic [15:0] r_sh_aux;
  logic [15:0] r_sh_ram;
  logic [11:0] r_sh_psu;

  logic        w_conv_load;
  logic [15:0] w_conv_result;
  logic        w_conv_valid;
  logic        w_wait_last;
  logic        w_unused_drp_lsbs;

  assign w_conv_load       = (r_state == ST_CONVERT);
  // Last allowed WAIT cycle; widened so a zero timeout cannot wrap.
  assign w_wait_last       = ({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, DRP_TIMEOUT};
  assign w_unused_drp_lsbs = ^drp.drp_do[3:0];

  xadc_code_convert u_convert (
    .clk          (clk),
    .rst          (rst),
    .load         (w_conv_load),
    .chan         (r_channel),
    .code12       (r_code12),
    .result       (w_conv_result),
    .result_valid (w_conv_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_channel     <= c_ch_temp;
      // Preloaded so the first sweep starts right after reset release.
      r_interval    <= POLL_INTERVAL;
      r_wait_cnt    <= 16'd0;
      r_code12      <= 12'd0;
      r_sh_temp     <= 16'd0;
      r_sh_core     <= 16'd0;
      r_sh_aux      <= 16'd0;
      r_sh_ram      <= 16'd0;
      r_sh_psu      <= 12'd0;
      drp.drp_en    <= 1'b0;
      drp.drp_addr  <= 7'd0;
      die_temp      <= 16'd0;
      volt_core     <= 16'd0;
      volt_ram      <= 16'd0;
      volt_aux      <= 16'd0;
      psu_temp      <= 12'd0;
      sample_valid  <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      drp.drp_en   <= 1'b0;
      sample_valid <= 1'b0;

      // The converter result lands during NEXT, before the channel advances.
      if (w_conv_valid) begin
        case (r_channel)
          c_ch_temp:    r_sh_temp <= w_conv_result;
          c_ch_vccint:  r_sh_core <= w_conv_result;
          c_ch_vccaux:  r_sh_aux  <= w_conv_result;
          c_ch_vccbram: r_sh_ram  <= w_conv_result;
          default:      r_sh_psu  <= w_conv_result[11:0];
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (r_interval >= POLL_INTERVAL) begin
            r_state      <= ST_ISSUE;
            r_channel    <= c_ch_temp;
            drp.drp_en   <= 1'b1;
            drp.drp_addr <= chan_addr(c_ch_temp, PSU_TEMP_ADDR);
          end else begin
            r_interval <= r_interval + 32'd1;
          end
        end
        ST_ISSUE: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= 16'd0;
        end
        ST_WAIT: begin
          if (drp.drp_rdy) begin
            r_code12 <= drp.drp_do[15:4];
            r_state  <= ST_CONVERT;
          end else if (w_wait_last) begin
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
            r_state <= ST_NEXT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        ST_CONVERT: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_channel == c_ch_psu) begin
            r_state <= ST_COMMIT;
          end else begin
            r_channel    <= r_channel + 3'd1;
            r_state      <= ST_ISSUE;
            drp.drp_en   <= 1'b1;
            drp.drp_addr <= chan_addr(r_channel + 3'd1, PSU_TEMP_ADDR);
          end
        end
        ST_COMMIT: begin
          die_temp     <= r_sh_temp;
          volt_core    <= r_sh_core;
          volt_aux     <= r_sh_aux;
          volt_ram     <= r_sh_ram;
          psu_temp     <= r_sh_psu;
          sample_valid <= 1'b1;
          r_interval   <= 32'd0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xadc_sensor_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xadc_sensor_poller                                           |
// | Purpose  : Scoreboard bench: a DRP responder answers reads from a table,    |
// |            expected strobes and published sets are queued by the stimulus  |
// |            and popped/compared by a monitor whenever the DUT presents them.|
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_xadc_sensor_poller;
  import xadc_sensor_poller_pkg::*;

  typedef struct {
    logic [15:0] temp;
    logic [15:0] core;
    logic [15:0] aux;
    logic [15:0] ram;
    logic [11:0] psu;
    logic [7:0]  tc;
    int          gap;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] die_temp, volt_core, volt_ram, volt_aux;
  logic [11:0] psu_temp;
  logic        sample_valid;
  logic [7:0]  timeout_count;

  xadc_sensor_poller_if drp_bus ();

  xadc_sensor_poller #(
    .POLL_INTERVAL (32'd20),
    .DRP_TIMEOUT   (16'd8),
    .PSU_TEMP_ADDR (7'h10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .drp           (drp_bus.master),
    .die_temp      (die_temp),
    .volt_core     (volt_core),
    .volt_ram      (volt_ram),
    .volt_aux      (volt_aux),
    .psu_temp      (psu_temp),
    .sample_valid  (sample_valid),
    .timeout_count (timeout_count)
  );

  int          checks = 0;
  int          failures = 0;
  int          n_samples = 0;
  int          cyc = 0;
  int          last_sv = 0;
  int          rsp_delay [5];
  logic [15:0] rsp_data [5];
  logic [6:0]  addr_tbl [5];
  logic [6:0]  exp_addr_q [$];
  exp_t        exp_s_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_rsp(input int ch, input int delay, input logic [15:0] data);
    rsp_delay[ch] = delay;   // 0 = never answer
    rsp_data[ch]  = data;
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(addr_tbl[i]);
  endtask

  task automatic push_exp(input logic [15:0] t, input logic [15:0] c, input logic [15:0] a,
                          input logic [15:0] r, input logic [11:0] p, input logic [7:0] tc,
                          input int gap);
    exp_t e;
    e.temp = t; e.core = c; e.aux = a; e.ram = r; e.psu = p; e.tc = tc; e.gap = gap;
    exp_s_q.push_back(e);
  endtask

  task automatic wait_samples(input int target, input int budget);
    for (int i = 0; i < budget && n_samples < target; i++) @(negedge clk);
    chk("wait_sample_valid", 32'(n_samples), 32'(target));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // DRP responder: raises drp_rdy for one cycle, delay cycles after the strobe.
  initial begin : responder
    int cnt;
    int cur;
    cnt = 0;
    cur = 0;
    forever begin
      @(negedge clk);
      drp_bus.drp_rdy = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_bus.drp_rdy = 1'b1;
          drp_bus.drp_do  = rsp_data[cur];
        end
      end
      if (drp_bus.drp_en) begin
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
          if (drp_bus.drp_addr == addr_tbl[i]) begin
            cur = i;
            cnt = rsp_delay[i];
          end
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT strobes DRP or publishes a set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (drp_bus.drp_en) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got addr 0x%0h, expected no strobe (cycle %0d)",
                   drp_bus.drp_addr, cyc);
        end else begin
          chk("drp_addr", 32'(drp_bus.drp_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (sample_valid) begin
        if (exp_s_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample_valid: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_s_q.pop_front();
          chk("die_temp",      32'(die_temp),      32'(e.temp));
          chk("volt_core",     32'(volt_core),     32'(e.core));
          chk("volt_aux",      32'(volt_aux),      32'(e.aux));
          chk("volt_ram",      32'(volt_ram),      32'(e.ram));
          chk("psu_temp",      32'(psu_temp),      32'(e.psu));
          chk("timeout_count", 32'(timeout_count), 32'(e.tc));
          if (e.gap != 0) chk("sample_gap", 32'(cyc - last_sv), 32'(e.gap));
        end
        last_sv = cyc;
        n_samples++;
      end
    end
  end

  initial begin : stimulus
    bit found;
    addr_tbl[0] = 7'h00; addr_tbl[1] = 7'h01; addr_tbl[2] = 7'h02;
    addr_tbl[3] = 7'h06; addr_tbl[4] = 7'h10;
    for (int i = 0; i < 5; i++) set_rsp(i, 0, 16'h0000);
    rst = 1'b1;
    drp_bus.drp_rdy = 1'b0;
    drp_bus.drp_do  = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_die_temp",      32'(die_temp),      32'h0);
    chk("rst_volt_core",     32'(volt_core),     32'h0);
    chk("rst_volt_aux",      32'(volt_aux),      32'h0);
    chk("rst_volt_ram",      32'(volt_ram),      32'h0);
    chk("rst_psu_temp",      32'(psu_temp),      32'h0);
    chk("rst_sample_valid",  32'(sample_valid),  32'h0);
    chk("rst_timeout_count", 32'(timeout_count), 32'h0);
    chk("rst_drp_en",        32'(drp_bus.drp_en), 32'h0);

    // Sweep 1: all answer after 2 cycles; PSU low nibble must be dropped.
    set_rsp(0, 2, 16'hFFF0); set_rsp(1, 2, 16'h0000); set_rsp(2, 2, 16'h5550);
    set_rsp(3, 2, 16'hAAA0); set_rsp(4, 2, 16'hABC5);
    push_addrs(5);
    push_exp(16'hE6BA, 16'h0000, 16'h00FF, 16'h01FF, 12'hABC, 8'd0, 0);
    rst = 1'b0;
    wait_samples(1, 200);

    // Sweep 2: temp saturates to 0; 2-cycle reads give 26 + 21 between pulses.
    set_rsp(0, 2, 16'h8000); set_rsp(1, 2, 16'hFFF0); set_rsp(2, 2, 16'h8000);
    set_rsp(3, 2, 16'h5550); set_rsp(4, 2, 16'h1230);
    push_addrs(5);
    push_exp(16'h0000, 16'h02FF, 16'h0180, 16'h00FF, 12'h123, 8'd0, 47);
    wait_samples(2, 200);

    // Sweep 3: mixed latencies, VCCAUX times out and its late strobe lands in NEXT.
    // Cycles: 4 + 6 + 10 + 7 + 4 + commit 1 = 32, plus 21 idle.
    set_rsp(0, 1, 16'h9C00); set_rsp(1, 3, 16'h5550); set_rsp(2, 9, 16'h0010);
    set_rsp(3, 4, 16'h4000); set_rsp(4, 1, 16'h7FF0);
    push_addrs(5);
    push_exp(16'h21FA, 16'h00FF, 16'h0180, 16'h00C0, 12'h7FF, 8'd1, 53);
    wait_samples(3, 200);

    // Sweep 4: reset while waiting on channel 2.
    set_rsp(0, 2, 16'h1230); set_rsp(1, 2, 16'h1230); set_rsp(2, 0, 16'h0000);
    push_addrs(3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (drp_bus.drp_en && drp_bus.drp_addr == 7'h02) found = 1'b1;
    end
    chk("wait_ch2_strobe", 32'(found), 32'h1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_die_temp",      32'(die_temp),       32'h0);
    chk("midrst_volt_core",     32'(volt_core),      32'h0);
    chk("midrst_volt_aux",      32'(volt_aux),       32'h0);
    chk("midrst_volt_ram",      32'(volt_ram),       32'h0);
    chk("midrst_psu_temp",      32'(psu_temp),       32'h0);
    chk("midrst_timeout_count", 32'(timeout_count),  32'h0);
    chk("midrst_drp_en",        32'(drp_bus.drp_en), 32'h0);
    repeat (2) @(negedge clk);

    // Sweep 5: fresh start; VCCBRAM times out so its cleared shadow (0) is published.
    set_rsp(0, 2, 16'h9C00); set_rsp(1, 2, 16'h5550); set_rsp(2, 2, 16'h8000);
    set_rsp(3, 0, 16'h0000); set_rsp(4, 2, 16'h0010);
    push_addrs(5);
    push_exp(16'h21FA, 16'h00FF, 16'h0180, 16'h0000, 12'h001, 8'd1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_drp_en",   32'(drp_bus.drp_en),   32'h1);
    chk("restart_drp_addr", 32'(drp_bus.drp_addr), 32'h0);
    wait_samples(4, 200);

    // Sweeps 6..65: nothing answers, 300 timeouts, counter saturates at 255.
    for (int i = 0; i < 5; i++) set_rsp(i, 0, 16'h0000);
    for (int n = 1; n <= 60; n++) begin
      push_addrs(5);
      push_exp(16'h21FA, 16'h00FF, 16'h0180, 16'h0000, 12'h001,
               (1 + 5 * n > 255) ? 8'hFF : 8'(1 + 5 * n), 0);
    end
    wait_samples(64, 6000);

    chk("addr_queue_drained",   32'(exp_addr_q.size()), 32'h0);
    chk("sample_queue_drained", 32'(exp_s_q.size()),    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
